booths_multiplier: RTL and testbench

Sequential signed multiplier using radix-2 Booth recoding. It takes two signed WIDTH-bit operands and produces a signed 2*WIDTH-bit product after WIDTH iteration cycles. A start/done handshake connects it to a controlling FSM or datapath. One multiplication is in flight at a time.

---
 rtl/booths_multiplier.sv | 90 +++++++++
 tb/tb_booths_multiplier.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/booths_multiplier.sv
// Sequential signed multiplier using radix-2 Booth recoding.
// One product every WIDTH+1 cycles; start/done handshake; done is a level held in DONE.
module booths_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   q;
  logic               qm1;
  logic [WIDTH-1:0]   m;
  logic [CW-1:0]      count;

  logic [WIDTH:0]     msext;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH+1:0] shifted;
  logic               accept;
  logic               last;

  // Accumulator is one bit wider than M so subtracting the most-negative M cannot overflow.
  always_comb begin
    msext   = {m[WIDTH-1], m};
    sum     = acc;
    case ({q[0], qm1})
      2'b10:   sum = acc - msext;
      2'b01:   sum = acc + msext;
      default: sum = acc;
    endcase
    shifted = {sum[WIDTH], sum, q};
    accept  = start && ((state == IDLE) || (state == DONE));
    last    = (count == COUNT_ONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      acc     <= '0;
      q       <= '0;
      qm1     <= 1'b0;
      m       <= '0;
      count   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            m     <= multiplicand;
            acc   <= '0;
            q     <= multiplier;
            qm1   <= 1'b0;
            count <= COUNT_INIT;
            done  <= 1'b0;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc   <= shifted[2*WIDTH+1:WIDTH+1];
          q     <= shifted[WIDTH:1];
          qm1   <= shifted[0];
          count <= count - COUNT_ONE;
          // Final iteration: publish the shifted {A,Q} on the same edge.
          if (last) begin
            product <= shifted[2*WIDTH:1];
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booths_multiplier.sv
// Directed and exhaustive checks of booths_multiplier (WIDTH=4) against hand-computed products.
module tb_booths_multiplier;

  localparam int WIDTH = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] multiplicand;
  logic [3:0] multiplier;
  logic [7:0] product;
  logic       done;

  int         errors;
  int         checks;
  logic [7:0] lastExp;

  booths_multiplier #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One start pulse, operands scrambled during BUSY; checks held product, latency and result.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic [7:0] exp, input string tag);
    int e;
    @(negedge clk);
    start = 1'b1; multiplicand = a; multiplier = b;
    @(negedge clk);
    start = 1'b0; multiplicand = ~a; multiplier = ~b;
    checkOutput({tag, "_busy"}, 16'(done), 16'd0);
    checkOutput({tag, "_held"}, 16'(product), 16'(lastExp));
    e = 0;
    while (!done && e < 20) begin
      @(negedge clk);
      e++;
    end
    checkOutput({tag, "_lat"}, 16'(e), 16'(WIDTH));
    checkOutput(tag, 16'(product), 16'(exp));
    lastExp = exp;
  endtask

  initial begin
    int e;
    errors = 0; checks = 0; lastExp = 8'h00;
    reset = 1'b0; start = 1'b0; multiplicand = 4'h0; multiplier = 4'h0;

    repeat (2) @(negedge clk);
    checkOutput("rst_prod", 16'(product), 16'h0000);
    checkOutput("rst_done", 16'(done), 16'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle_prod", 16'(product), 16'h0000);
    checkOutput("idle_done", 16'(done), 16'd0);

    applyStimulus(4'h3, 4'h2, 8'h06, "3x2");
    applyStimulus(4'hC, 4'h3, 8'hF4, "m4x3");
    applyStimulus(4'hD, 4'hE, 8'h06, "m3xm2");
    applyStimulus(4'h0, 4'hD, 8'h00, "0xm3");
    applyStimulus(4'h8, 4'h8, 8'h40, "m8xm8");
    applyStimulus(4'h8, 4'h7, 8'hC8, "m8x7");
    applyStimulus(4'h7, 4'h7, 8'h31, "7x7");
    applyStimulus(4'hF, 4'hF, 8'h01, "m1xm1");

    // Re-pulse start mid-BUSY with other operands: must be ignored.
    @(negedge clk);
    start = 1'b1; multiplicand = 4'h7; multiplier = 4'h6;
    @(negedge clk);
    start = 1'b0; multiplicand = 4'hF; multiplier = 4'hF;
    @(negedge clk);
    start = 1'b1; multiplicand = 4'h1; multiplier = 4'h1;
    @(negedge clk);
    start = 1'b0;
    e = 2;
    while (!done && e < 20) begin
      @(negedge clk);
      e++;
    end
    checkOutput("repulse_lat", 16'(e), 16'(WIDTH));
    checkOutput("repulse", 16'(product), 16'h002A);

    // start held high: restart from DONE after exactly one done cycle.
    @(negedge clk);
    start = 1'b1; multiplicand = 4'h2; multiplier = 4'h3;
    @(negedge clk);
    multiplicand = 4'h8; multiplier = 4'h8;
    checkOutput("hold_busy", 16'(done), 16'd0);
    e = 0;
    while (!done && e < 20) begin
      @(negedge clk);
      e++;
    end
    checkOutput("hold_lat1", 16'(e), 16'(WIDTH));
    checkOutput("hold_res1", 16'(product), 16'h0006);
    @(negedge clk);
    checkOutput("hold_1cyc", 16'(done), 16'd0);
    e = 0;
    while (!done && e < 20) begin
      @(negedge clk);
      e++;
    end
    start = 1'b0;
    checkOutput("hold_lat2", 16'(e), 16'(WIDTH));
    checkOutput("hold_res2", 16'(product), 16'h0040);
    @(negedge clk);
    checkOutput("done_level", 16'(done), 16'd1);
    checkOutput("prod_level", 16'(product), 16'h0040);
    lastExp = 8'h40;

    // Asynchronous reset two iterations into an operation.
    @(negedge clk);
    start = 1'b1; multiplicand = 4'h7; multiplier = 4'h7;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_prod", 16'(product), 16'h0000);
    checkOutput("async_done", 16'(done), 16'd0);
    @(negedge clk);
    reset = 1'b1;
    lastExp = 8'h00;
    applyStimulus(4'h5, 4'hD, 8'hF1, "5xm3");

    for (int i = -8; i < 8; i++) begin
      for (int j = -8; j < 8; j++) begin
        int p;
        logic [3:0] a;
        logic [3:0] b;
        a = i[3:0];
        b = j[3:0];
        p = i * j;
        applyStimulus(a, b, p[7:0], $sformatf("sw_%0d_%0d", i, j));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
